// File: rtl/pe_timer.sv
// pe_timer: memory-mapped programmable down-counting timer for the bridge bus.
// Five word-spaced registers starting at BASE: CTRL, PRESCALE, LOAD, COUNT, STATUS.
// A prescaler divides the clock into ticks. Each tick decrements COUNT.
// When COUNT reaches zero, the timer sets a sticky expiry flag and then
// either reloads COUNT from LOAD or stops (one-shot mode).
module pe_timer #(
  parameter logic [11:0] BASE = 12'h020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] addr,
  input  logic        wen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [11:0] OFF_CTRL     = BASE + 12'h000;
  localparam logic [11:0] OFF_PRESCALE = BASE + 12'h004;
  localparam logic [11:0] OFF_LOAD     = BASE + 12'h008;
  localparam logic [11:0] OFF_COUNT    = BASE + 12'h00C;
  localparam logic [11:0] OFF_STATUS   = BASE + 12'h010;

  logic        en;
  logic        auto_rl;
  logic        ie;
  logic [15:0] prescale;
  logic [31:0] load;
  logic [31:0] count;
  logic        exp_flag;
  logic [15:0] pc;

  logic wr_ctrl;
  logic wr_prescale;
  logic wr_load;
  logic wr_count;
  logic wr_status;
  logic tick;
  logic expire;

  assign wr_ctrl     = wen && (addr == OFF_CTRL);
  assign wr_prescale = wen && (addr == OFF_PRESCALE);
  assign wr_load     = wen && (addr == OFF_LOAD);
  assign wr_count    = wen && (addr == OFF_COUNT);
  assign wr_status   = wen && (addr == OFF_STATUS);

  assign tick   = en && (pc == prescale);
  assign expire = tick && (count == 32'd0);

  assign irq = exp_flag & ie;

  // Control bits: a CTRL write beats the one-shot self-stop on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      en      <= 1'b0;
      auto_rl <= 1'b0;
      ie      <= 1'b0;
    end else if (wr_ctrl) begin
      en      <= wdata[0];
      auto_rl <= wdata[1];
      ie      <= wdata[2];
    end else if (expire && !auto_rl) begin
      en <= 1'b0;
    end
  end

  // Prescale and reload registers are plain software-written storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= 16'd0;
      load     <= 32'd0;
    end else begin
      if (wr_prescale) prescale <= wdata[15:0];
      if (wr_load)     load     <= wdata;
    end
  end

  // Prescaler counter: restarts on a PRESCALE write or on enable, wraps on tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= 16'd0;
    end else if (wr_prescale) begin
      pc <= 16'd0;
    end else if (wr_ctrl && !en && wdata[0]) begin
      pc <= 16'd0;
    end else if (en) begin
      pc <= tick ? 16'd0 : pc + 16'd1;
    end
  end

  // Main count: a software write wins over the tick; decrement never underflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 32'd0;
    end else if (wr_count) begin
      count <= wdata;
    end else if (tick) begin
      if (count != 32'd0) begin
        count <= count - 32'd1;
      end else if (auto_rl) begin
        count <= load;
      end
    end
  end

  // Sticky expiry flag: setting it beats a simultaneous write-1-to-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_flag <= 1'b0;
    end else if (expire) begin
      exp_flag <= 1'b1;
    end else if (wr_status && wdata[0]) begin
      exp_flag <= 1'b0;
    end
  end

  // Zero-latency read mux; unmapped offsets read as zero.
  always_comb begin
    rdata = 32'd0;
    case (addr)
      OFF_CTRL:     rdata = {29'd0, ie, auto_rl, en};
      OFF_PRESCALE: rdata = {16'd0, prescale};
      OFF_LOAD:     rdata = load;
      OFF_COUNT:    rdata = count;
      OFF_STATUS:   rdata = {31'd0, exp_flag};
      default:      rdata = 32'd0;
    endcase
  end

endmodule
